costas_lock_ctrl: RTL and testbench
===================================

Name: costas_lock_ctrl

Overview:
- Lock detector and loop-gain scheduler for the QPSK Costas loop.
- Watches the de-rotated I/Q stream at the mixer output and measures lock quality over fixed sample windows.
- Runs an acquire/verify/track state machine that drives the loop filter's gain select (wide for acquisition, narrow for tracking) and the lock flag.
- Pulses a clear to the loop's phase accumulator when lock is lost.

Parameters:
- WIN_LOG2, 8, log2 of window length in valid samples (window N = 2^WIN_LOG2).
- LOCK_SHIFT, 3, window counts as locked when err_acc < (mag_acc >> LOCK_SHIFT).
- UNLOCK_SHIFT, 1, in TRACK, window counts as unlocked when err_acc >= (mag_acc >> UNLOCK_SHIFT); this provides hysteresis.
- LOCK_WINDOWS, 4, consecutive locked windows needed to enter TRACK.
- UNLOCK_WINDOWS, 2, consecutive unlocked windows needed to drop out of TRACK.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  0 forces IDLE.
- restart  in  1  single-cycle pulse that forces re-acquisition.
- s_i_tdata  in  16  signed mixer output I, fix16_15.
- s_q_tdata  in  16  signed mixer output Q, fix16_15.
- s_tvalid  in  1  sample strobe (no backpressure; the block always accepts).
- gain_sel  out  1  0 = wide acquisition gains, 1 = narrow tracking gains.
- locked  out  1  high in TRACK.
- loop_clear  out  1  one-cycle pulse that clears the phase accumulator.
- window_done  out  1  one-cycle pulse per evaluated window.
- state_dbg  out  2  current state encoding.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters and accumulators 0.
- States: IDLE=0, ACQ=1, VERIFY=2, TRACK=3.
- Stage 1 (registered, 1 cycle): a=|I|, b=|Q|, each saturating at 32767 (-32768 maps to 32767).
  - mag = a+b (17 bit).
  - err = |a-b| (16 bit).
  - v1 = s_tvalid.
- Stage 2: on v1, mag_acc += mag and err_acc += err; sample count increments.
  - Accumulator widths are 17+WIN_LOG2 and 16+WIN_LOG2, so they cannot overflow.
- On the N-th accumulated sample, the following cycle compares the accumulators using the threshold for the current state:
  - ACQ and VERIFY use LOCK_SHIFT.
  - TRACK uses the UNLOCK_SHIFT test.
- The compare cycle pulses window_done and zeroes both accumulators and the count.
  - If a valid sample arrives in that same cycle, it seeds the new window (acc = sample value, count = 1) and is not lost.
- Latency from the last window sample at the input to window_done: 3 cycles.
- Transitions, evaluated only on window_done unless noted:
  - IDLE -> ACQ when enable=1. This is immediate, not window-gated. It pulses loop_clear and clears the window.
  - ACQ -> VERIFY on a locked window; lock_cnt=1.
  - VERIFY, locked window: lock_cnt++. When lock_cnt reaches LOCK_WINDOWS, go to TRACK; gain_sel and locked are set 1 in the same cycle as the state change.
  - VERIFY, unlocked window: go to ACQ, lock_cnt=0. No loop_clear.
  - TRACK, unlocked window: unlock_cnt++. When it reaches UNLOCK_WINDOWS, go to ACQ; gain_sel=0, locked=0, pulse loop_clear.
  - TRACK, locked window: unlock_cnt=0.
- Priority, highest first: aresetn, enable=0, restart, window decision.
  - enable=0 -> IDLE in any state; outputs go 0 next cycle; the window is cleared.
  - restart with enable=1 -> ACQ from any state; pulse loop_clear; counters and window cleared; an in-flight window decision is discarded.
- With LOCK_WINDOWS=1, ACQ -> TRACK happens directly on one locked window (VERIFY is skipped).
- Async reset mid-window: the partial window is discarded and there is no loop_clear pulse.

Decomposition:
- Package costas_pkg holds:
  - state enum (IDLE/ACQ/VERIFY/TRACK);
  - 16-bit sample width constant;
  - gain_sel encoding constants GAIN_WIDE=0, GAIN_NARROW=1.
- One sub-module, costas_lock_metric: the abs/mag/err stage plus windowed accumulators and compare.
  - It outputs window_done, win_locked and win_unlocked.
  - The FSM stays in the top.

Test Plan:
1. Reset then enable=1 -> next cycle state_dbg=1, loop_clear pulses once, gain_sel=0, locked=0.
2. Locked stream: constant I=Q=0x2000 (err=0, mag=0x4000 per sample), defaults -> window_done every 256 samples. After the 4th window locked=1 and gain_sel=1, at 4*256 samples + 3 cycles.
3. From TRACK, I=0x4000, Q=0 (err=mag) -> unlock after 2 windows: state ACQ, loop_clear pulse, gain_sel=0.
4. From TRACK, alternating locked and unlocked windows -> unlock_cnt resets, locked stays 1 throughout.
5. VERIFY after 2 locked windows, then restart pulse -> ACQ next cycle, loop_clear pulse, lock_cnt=0; 4 further locked windows are needed for TRACK.
6. s_tvalid gaps (1 valid sample every 3 cycles) plus a sample arriving in the compare cycle, I=-32768, Q=32767 -> no sample dropped, a=32767, err=0, window locked; an aresetn assert mid-window leaves all outputs 0.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared types and constants for the Costas loop lock controller.
package costas_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic GAIN_WIDE   = 1'b0;
    localparam logic GAIN_NARROW = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_TRACK  = 2'd3
    } state_e;

endpackage

// File: rtl/costas_lock_metric.sv
// Per-sample |I|+|Q| / ||I|-|Q|| measurement, windowed accumulation and
// lock / unlock threshold tests for the Costas lock controller.
module costas_lock_metric
    import costas_pkg::*;
#(
    parameter int WIN_LOG2     = 8,
    parameter int LOCK_SHIFT   = 3,
    parameter int UNLOCK_SHIFT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic signed [SAMPLE_W-1:0] i_i,
    input  logic signed [SAMPLE_W-1:0] q_i,
    input  logic                       vld_i,
    output logic                       window_done_o,
    output logic                       win_locked_o,
    output logic                       win_unlocked_o
);

    localparam int MAG_W  = SAMPLE_W + 1;
    localparam int ERR_W  = SAMPLE_W;
    localparam int MACC_W = MAG_W + WIN_LOG2;
    localparam int EACC_W = ERR_W + WIN_LOG2;
    localparam int CNT_W  = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] WIN_N = CNT_W'(1 << WIN_LOG2);

    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic        [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    // -32768 has no positive counterpart; clamp it instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x == S_MIN)             r = S_MAX;
        else if (x[SAMPLE_W-1])     r = $unsigned(-x);
        else                        r = $unsigned(x);
        return r;
    endfunction

    logic [SAMPLE_W-1:0] a, b;
    logic [MAG_W-1:0]    mag;
    logic [ERR_W-1:0]    err;

    always_comb begin
        a   = sat_abs(i_i);
        b   = sat_abs(q_i);
        mag = MAG_W'(a) + MAG_W'(b);
        err = (a >= b) ? (a - b) : (b - a);
    end

    // ---- stage 1 -> stage 2 boundary
    logic [MAG_W-1:0] mag_p1_q;
    logic [ERR_W-1:0] err_p1_q;
    logic             vld_p1_q;

    always_ff @(posedge clk_i) begin
        mag_p1_q <= mag;
        err_p1_q <= err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) vld_p1_q <= 1'b0;
        else         vld_p1_q <= vld_i;
    end

    // ---- stage 2: window accumulators
    logic [MACC_W-1:0] mag_acc_q, mag_acc_d;
    logic [EACC_W-1:0] err_acc_q, err_acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign window_done_o  = (cnt_q == WIN_N);
    assign win_locked_o   = MACC_W'(err_acc_q) <  (mag_acc_q >> LOCK_SHIFT);
    assign win_unlocked_o = MACC_W'(err_acc_q) >= (mag_acc_q >> UNLOCK_SHIFT);

    always_comb begin
        mag_acc_d = mag_acc_q;
        err_acc_d = err_acc_q;
        cnt_d     = cnt_q;
        if (clr_i) begin
            mag_acc_d = '0;
            err_acc_d = '0;
            cnt_d     = '0;
        end else if (window_done_o) begin
            // A sample landing on the compare cycle opens the next window.
            mag_acc_d = vld_p1_q ? MACC_W'(mag_p1_q) : '0;
            err_acc_d = vld_p1_q ? EACC_W'(err_p1_q) : '0;
            cnt_d     = vld_p1_q ? CNT_W'(1) : '0;
        end else if (vld_p1_q) begin
            mag_acc_d = mag_acc_q + MACC_W'(mag_p1_q);
            err_acc_d = err_acc_q + EACC_W'(err_p1_q);
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_acc_q <= '0;
            err_acc_q <= '0;
            cnt_q     <= '0;
        end else begin
            mag_acc_q <= mag_acc_d;
            err_acc_q <= err_acc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/costas_lock_ctrl.sv
// Costas loop lock detector and gain scheduler: IDLE/ACQ/VERIFY/TRACK FSM
// driven by windowed lock-quality decisions from costas_lock_metric.
module costas_lock_ctrl
    import costas_pkg::*;
#(
    parameter int WIN_LOG2       = 8,
    parameter int LOCK_SHIFT     = 3,
    parameter int UNLOCK_SHIFT   = 1,
    parameter int LOCK_WINDOWS   = 4,
    parameter int UNLOCK_WINDOWS = 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable,
    input  logic                       restart,
    input  logic signed [SAMPLE_W-1:0] s_i_tdata,
    input  logic signed [SAMPLE_W-1:0] s_q_tdata,
    input  logic                       s_tvalid,
    output logic                       gain_sel,
    output logic                       locked,
    output logic                       loop_clear,
    output logic                       window_done,
    output logic [1:0]                 state_dbg
);

    localparam int LCW = $clog2(LOCK_WINDOWS + 1);
    localparam int UCW = $clog2(UNLOCK_WINDOWS + 1);
    localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_WINDOWS - 1);
    localparam logic [UCW-1:0] UNLOCK_LAST = UCW'(UNLOCK_WINDOWS - 1);

    state_e         state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic [UCW-1:0] unlock_cnt_q, unlock_cnt_d;
    logic           gain_sel_q, gain_sel_d;
    logic           locked_q, locked_d;
    logic           loop_clear_q, loop_clear_d;
    logic           window_done_q, window_done_d;

    logic win_done, win_locked, win_unlocked, clr;

    // IDLE holds the window empty; restart / disable discard any partial window.
    assign clr = !enable || restart || (state_q == ST_IDLE);

    costas_lock_metric #(
        .WIN_LOG2     (WIN_LOG2),
        .LOCK_SHIFT   (LOCK_SHIFT),
        .UNLOCK_SHIFT (UNLOCK_SHIFT)
    ) u_metric (
        .clk_i          (aclk),
        .rst_ni         (aresetn),
        .clr_i          (clr),
        .i_i            (s_i_tdata),
        .q_i            (s_q_tdata),
        .vld_i          (s_tvalid),
        .window_done_o  (win_done),
        .win_locked_o   (win_locked),
        .win_unlocked_o (win_unlocked)
    );

    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        unlock_cnt_d  = unlock_cnt_q;
        gain_sel_d    = gain_sel_q;
        locked_d      = locked_q;
        loop_clear_d  = 1'b0;
        window_done_d = 1'b0;
        if (!enable) begin
            state_d      = ST_IDLE;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            gain_sel_d   = GAIN_WIDE;
            locked_d     = 1'b0;
        end else if (restart || state_q == ST_IDLE) begin
            state_d      = ST_ACQ;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            gain_sel_d   = GAIN_WIDE;
            locked_d     = 1'b0;
            loop_clear_d = 1'b1;
        end else if (win_done) begin
            window_done_d = 1'b1;
            case (state_q)
                ST_ACQ: begin
                    if (win_locked && LOCK_WINDOWS == 1) begin
                        state_d      = ST_TRACK;
                        unlock_cnt_d = '0;
                        gain_sel_d   = GAIN_NARROW;
                        locked_d     = 1'b1;
                    end else if (win_locked) begin
                        state_d    = ST_VERIFY;
                        lock_cnt_d = LCW'(1);
                    end
                end
                ST_VERIFY: begin
                    if (!win_locked) begin
                        state_d    = ST_ACQ;
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d      = ST_TRACK;
                        lock_cnt_d   = '0;
                        unlock_cnt_d = '0;
                        gain_sel_d   = GAIN_NARROW;
                        locked_d     = 1'b1;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end
                end
                ST_TRACK: begin
                    if (!win_unlocked) begin
                        unlock_cnt_d = '0;
                    end else if (unlock_cnt_q == UNLOCK_LAST) begin
                        state_d      = ST_ACQ;
                        unlock_cnt_d = '0;
                        gain_sel_d   = GAIN_WIDE;
                        locked_d     = 1'b0;
                        loop_clear_d = 1'b1;
                    end else begin
                        unlock_cnt_d = unlock_cnt_q + UCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            lock_cnt_q    <= '0;
            unlock_cnt_q  <= '0;
            gain_sel_q    <= GAIN_WIDE;
            locked_q      <= 1'b0;
            loop_clear_q  <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            unlock_cnt_q  <= unlock_cnt_d;
            gain_sel_q    <= gain_sel_d;
            locked_q      <= locked_d;
            loop_clear_q  <= loop_clear_d;
            window_done_q <= window_done_d;
        end
    end

    assign gain_sel    = gain_sel_q;
    assign locked      = locked_q;
    assign loop_clear  = loop_clear_q;
    assign window_done = window_done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Scoreboard bench for costas_lock_ctrl: a behavioural window/FSM model
// predicts each window_done (cycle, state, locked, gain_sel, loop_clear).
module tb_costas_lock_ctrl;

    logic               aclk = 1'b0;
    logic               aresetn, enable, restart, s_tvalid;
    logic signed [15:0] s_i_tdata, s_q_tdata;
    logic               gain_sel, locked, loop_clear, window_done;
    logic [1:0]         state_dbg;

    costas_lock_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .enable      (enable),
        .restart     (restart),
        .s_i_tdata   (s_i_tdata),
        .s_q_tdata   (s_q_tdata),
        .s_tvalid    (s_tvalid),
        .gain_sel    (gain_sel),
        .locked      (locked),
        .loop_clear  (loop_clear),
        .window_done (window_done),
        .state_dbg   (state_dbg)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       lk;
        logic       gs;
        logic       lc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;

    int     m_state, m_lock, m_unlock, m_cnt;
    longint m_mag, m_err;

    function automatic int abs_sat(input int x);
        int r;
        r = (x < 0) ? -x : x;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    task automatic model_clear();
        m_mag = 0;
        m_err = 0;
        m_cnt = 0;
    endtask

    task automatic model_sample(input int i, input int q);
        int   a, b;
        bit   lk, ul, lc;
        exp_t e;
        a = abs_sat(i);
        b = abs_sat(q);
        m_mag += a + b;
        m_err += (a > b) ? (a - b) : (b - a);
        m_cnt++;
        if (m_cnt == 256) begin
            lk = (m_err < (m_mag >>> 3));
            ul = (m_err >= (m_mag >>> 1));
            lc = 1'b0;
            case (m_state)
                1: if (lk) begin m_state = 2; m_lock = 1; end
                2: begin
                    if (!lk) begin m_state = 1; m_lock = 0; end
                    else begin
                        m_lock++;
                        if (m_lock == 4) begin m_state = 3; m_unlock = 0; end
                    end
                end
                3: begin
                    if (!ul) m_unlock = 0;
                    else begin
                        m_unlock++;
                        if (m_unlock == 2) begin m_state = 1; m_unlock = 0; lc = 1'b1; end
                    end
                end
                default: ;
            endcase
            e.cyc = cyc + 3;
            e.st  = 2'(m_state);
            e.lk  = (m_state == 3);
            e.gs  = (m_state == 3);
            e.lc  = lc;
            sb.push_back(e);
            model_clear();
        end
    endtask

    task automatic drive(input int i, input int q, input bit v);
        @(posedge aclk);
        #1;
        s_i_tdata = 16'(i);
        s_q_tdata = 16'(q);
        s_tvalid  = v;
        if (v) model_sample(i, q);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0);
    endtask

    task automatic drive_windows(input int i, input int q, input int nwin);
        for (int k = 0; k < 256 * nwin; k++) drive(i, q, 1'b1);
    endtask

    task automatic pulse_restart();
        idle(4);
        @(posedge aclk);
        #1;
        restart  = 1'b1;
        s_tvalid = 1'b0;
        m_state  = 1;
        m_lock   = 0;
        m_unlock = 0;
        model_clear();
        @(posedge aclk);
        #1;
        restart = 1'b0;
    endtask

    // Window decisions are checked against the scoreboard as they appear.
    always @(posedge aclk) begin
        #1;
        if (aresetn === 1'b1 && window_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL window_done_unexpected at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL window_latency got cycle %0d expected %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (state_dbg !== mon_e.st) begin
                    errors++;
                    $display("FAIL window_state got %0d expected %0d (cycle %0d)", state_dbg, mon_e.st, cyc);
                end
                checks++;
                if (locked !== mon_e.lk || gain_sel !== mon_e.gs) begin
                    errors++;
                    $display("FAIL window_lock_gain got %b/%b expected %b/%b (cycle %0d)",
                             locked, gain_sel, mon_e.lk, mon_e.gs, cyc);
                end
                checks++;
                if (loop_clear !== mon_e.lc) begin
                    errors++;
                    $display("FAIL window_loop_clear got %b expected %b (cycle %0d)", loop_clear, mon_e.lc, cyc);
                end
            end
        end
    end

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b0; restart = 1'b0; s_tvalid = 1'b0;
        s_i_tdata = '0; s_q_tdata = '0;
        m_state = 0; m_lock = 0; m_unlock = 0;
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({state_dbg, gain_sel, locked, loop_clear, window_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got st=%0d gs=%b lk=%b lc=%b wd=%b expected all 0",
                     state_dbg, gain_sel, locked, loop_clear, window_done);
        end
        aresetn = 1'b1;
        idle(3);
        checks++;
        if (state_dbg !== 2'd0 || loop_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_disabled got st=%0d lc=%b expected 0/0", state_dbg, loop_clear);
        end
    endtask

    task automatic test_enable();
        @(posedge aclk);
        #1;
        enable  = 1'b1;
        m_state = 1;
        model_clear();
        @(posedge aclk);
        #1;
        checks++;
        if (state_dbg !== 2'd1 || loop_clear !== 1'b1 || gain_sel !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL enable_to_acq got st=%0d lc=%b gs=%b lk=%b expected 1/1/0/0",
                     state_dbg, loop_clear, gain_sel, locked);
        end
        @(posedge aclk);
        #1;
        checks++;
        if (loop_clear !== 1'b0) begin
            errors++;
            $display("FAIL enable_clear_single got %b expected 0", loop_clear);
        end
    endtask

    task automatic test_lock_acquire();
        drive_windows(16'sh2000, 16'sh2000, 4);
        idle(4);
        checks++;
        if (state_dbg !== 2'd3 || locked !== 1'b1 || gain_sel !== 1'b1) begin
            errors++;
            $display("FAIL lock_acquire got st=%0d lk=%b gs=%b expected 3/1/1", state_dbg, locked, gain_sel);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL lock_acquire_pending got %0d windows outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_unlock();
        drive_windows(16'sh4000, 0, 2);
        idle(4);
        checks++;
        if (state_dbg !== 2'd1 || locked !== 1'b0 || gain_sel !== 1'b0) begin
            errors++;
            $display("FAIL unlock got st=%0d lk=%b gs=%b expected 1/0/0", state_dbg, locked, gain_sel);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL unlock_pending got %0d windows outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_alternate();
        drive_windows(16'sh2000, 16'sh2000, 4);
        for (int r = 0; r < 2; r++) begin
            drive_windows(16'sh4000, 0, 1);
            drive_windows(16'sh2000, 16'sh2000, 1);
        end
        idle(4);
        checks++;
        if (state_dbg !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL alternate_hold got st=%0d lk=%b expected 3/1", state_dbg, locked);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL alternate_pending got %0d windows outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_restart();
        pulse_restart();
        checks++;
        if (state_dbg !== 2'd1 || loop_clear !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_track got st=%0d lc=%b lk=%b expected 1/1/0", state_dbg, loop_clear, locked);
        end
        drive_windows(16'sh2000, 16'sh2000, 2);
        idle(4);
        checks++;
        if (state_dbg !== 2'd2) begin
            errors++;
            $display("FAIL restart_verify got st=%0d expected 2", state_dbg);
        end
        pulse_restart();
        checks++;
        if (state_dbg !== 2'd1 || loop_clear !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_verify got st=%0d lc=%b expected 1/1", state_dbg, loop_clear);
        end
        drive_windows(16'sh2000, 16'sh2000, 3);
        idle(4);
        checks++;
        if (state_dbg !== 2'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL restart_lockcnt_cleared got st=%0d lk=%b expected 2/0", state_dbg, locked);
        end
        drive_windows(16'sh2000, 16'sh2000, 1);
        idle(4);
        checks++;
        if (state_dbg !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL restart_relock got st=%0d lk=%b expected 3/1", state_dbg, locked);
        end
    endtask

    task automatic test_gaps();
        pulse_restart();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 256; k++) begin
                drive(-32768, 32767, 1'b1);
                if (!(w == 0 && k == 255)) idle(2);
            end
        end
        idle(4);
        checks++;
        if (state_dbg !== 2'd2) begin
            errors++;
            $display("FAIL gaps_verify got st=%0d expected 2", state_dbg);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL gaps_pending got %0d windows outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_disable();
        @(posedge aclk);
        #1;
        enable  = 1'b0;
        m_state = 0;
        model_clear();
        @(posedge aclk);
        #1;
        checks++;
        if ({state_dbg, gain_sel, locked, loop_clear} !== 5'b0) begin
            errors++;
            $display("FAIL disable_idle got st=%0d gs=%b lk=%b lc=%b expected all 0",
                     state_dbg, gain_sel, locked, loop_clear);
        end
    endtask

    task automatic test_async_reset();
        @(posedge aclk);
        #1;
        enable  = 1'b1;
        m_state = 1;
        model_clear();
        idle(1);
        for (int k = 0; k < 100; k++) drive(16'sh2000, 16'sh2000, 1'b1);
        @(posedge aclk);
        #3;
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        enable   = 1'b0;
        m_state  = 0;
        model_clear();
        #1;
        checks++;
        if ({state_dbg, gain_sel, locked, loop_clear, window_done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_outputs got st=%0d gs=%b lk=%b lc=%b wd=%b expected all 0",
                     state_dbg, gain_sel, locked, loop_clear, window_done);
        end
        idle(2);
        aresetn = 1'b1;
        idle(2);
        checks++;
        if (state_dbg !== 2'd0 || loop_clear !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_release got st=%0d lc=%b expected 0/0", state_dbg, loop_clear);
        end
        @(posedge aclk);
        #1;
        enable  = 1'b1;
        m_state = 1;
        model_clear();
        idle(1);
        drive_windows(16'sh2000, 16'sh2000, 1);
        idle(4);
        checks++;
        if (state_dbg !== 2'd2 || sb.size() != 0) begin
            errors++;
            $display("FAIL async_reset_fresh_window got st=%0d pending=%0d expected 2/0", state_dbg, sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable();
        test_lock_acquire();
        test_unlock();
        test_alternate();
        test_restart();
        test_gaps();
        test_disable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
